pkt_read_sequencer: RTL and testbench

PKT_READ_SEQUENCER -- requirements
Module: pkt_read_sequencer

---
 rtl/pkt_read_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_pkt_read_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_read_sequencer.sv
// Packet read sequencer: streams L words per enabled channel from memory (or a self-test
// pattern) through a 2-entry fall-through buffer. Define PKT_SEQ_CHKSUM_EN for a checksum beat.
module pkt_read_sequencer #(
    parameter int DATA_W   = 18,
    parameter int ADDR_W   = 16,
    parameter int NUM_CH   = 4,
    parameter int BASE_LEN = 216
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      cfg_start,
    input  logic                      cfg_again,
    input  logic [1:0]                cfg_data_len,
    input  logic [1:0]                cfg_idle_len,
    input  logic [3:0]                cfg_gap,
    input  logic [NUM_CH-1:0]         cfg_ch_en,
    input  logic                      cfg_self_test,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [DATA_W-1:0]         dout,
    output logic [$clog2(NUM_CH)-1:0] dout_ch,
    output logic                      dout_sop,
    output logic                      dout_eop,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                seq_num
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int OFF_W = ADDR_W - CH_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_TAIL = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CH_W-1:0]   ch;
        logic              sop;
        logic              eop;
    } beat_t;

    logic [2:0]        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              issued_q, issued_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        len_sel_q, len_sel_d, idle_sel_q, idle_sel_d;
    logic [3:0]        gap_q, gap_d;
    logic [NUM_CH-1:0] ch_en_q, ch_en_d;
    logic              self_test_q, self_test_d;
    logic [7:0]        seq_q, seq_d;
    logic              done_q, done_d;
    logic              pend_q, pend_sop_q, pend_eop_q;
    logic [CH_W-1:0]   pend_ch_q;
    logic [OFF_W-1:0]  pend_off_q;
    logic [1:0]        occ_q, occ_d;
    beat_t             buf0_q, buf0_d, buf1_q, buf1_d;

    logic [OFF_W-1:0]  pkt_len, last_off;
    logic              last_slot, issue, out_valid, pop;
    logic [DATA_W-1:0] src_data;
    beat_t             arr, head, out_beat;
    logic [CH_W:0]     first_pick, next_pick;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [CH_W:0] first_from(input logic [NUM_CH-1:0] mask, input int from);
        logic [CH_W:0] res;
        res = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (mask[i] && i >= from) res = {1'b1, CH_W'(i)};
        return res;
    endfunction

    function automatic logic [7:0] tail_cnt(input logic [1:0] sel);
        return (8'd16 << sel) - 8'd1;
    endfunction

    assign pkt_len   = OFF_W'(BASE_LEN) << len_sel_q;
    assign last_slot = (off_q == last_off);
    // A read may only be launched if its data is guaranteed a buffer slot on arrival.
    assign issue     = (state_q == S_READ) && !issued_q && ((occ_q + {1'b0, pend_q}) < 2'd2);
    assign mem_addr  = {ch_q, off_q};
    assign src_data  = self_test_q ? DATA_W'({pend_ch_q, pend_off_q}) : mem_rdata;

`ifdef PKT_SEQ_CHKSUM_EN
    logic              pend_cks_q;
    logic [DATA_W-1:0] sum_q, sum_d;

    // The checksum occupies slot offset L, issued like a read but served from sum_q.
    assign last_off  = pkt_len;
    assign mem_rd_en = issue && !self_test_q && (off_q != pkt_len);

    always_comb begin
        arr.data = pend_cks_q ? sum_q : src_data;
        arr.ch   = pend_ch_q;
        arr.sop  = pend_sop_q;
        arr.eop  = pend_eop_q;
        sum_d    = sum_q;
        if (pend_q && !pend_cks_q) sum_d = pend_sop_q ? src_data : sum_q + src_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_cks_q <= 1'b0;
            sum_q      <= '0;
        end else begin
            pend_cks_q <= (off_q == pkt_len);
            sum_q      <= sum_d;
        end
    end
`else
    assign last_off  = pkt_len - OFF_W'(1);
    assign mem_rd_en = issue && !self_test_q;

    always_comb begin
        arr.data = src_data;
        arr.ch   = pend_ch_q;
        arr.sop  = pend_sop_q;
        arr.eop  = pend_eop_q;
    end
`endif

    assign out_valid  = (occ_q != 2'd0) || pend_q;
    assign head       = (occ_q != 2'd0) ? buf0_q : arr;
    assign out_beat   = out_valid ? head : '0;
    assign pop        = out_valid && dout_ready;
    assign dout       = out_beat.data;
    assign dout_ch    = out_beat.ch;
    assign dout_sop   = out_beat.sop;
    assign dout_eop   = out_beat.eop;
    assign dout_valid = out_valid;
    assign busy       = (state_q == S_READ) || (state_q == S_GAP) || (state_q == S_TAIL);
    assign done       = done_q;
    assign seq_num    = seq_q;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        case (occ_q)
            2'd0: if (pend_q && !pop) begin buf0_d = arr; occ_d = 2'd1; end
            2'd1: begin
                if (pop) begin
                    if (pend_q) buf0_d = arr;
                    else        occ_d  = 2'd0;
                end else if (pend_q) begin
                    buf1_d = arr;
                    occ_d  = 2'd2;
                end
            end
            default: if (pop) begin buf0_d = buf1_q; occ_d = 2'd1; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        off_d       = off_q;
        issued_d    = issued_q;
        cnt_d       = cnt_q;
        len_sel_d   = len_sel_q;
        idle_sel_d  = idle_sel_q;
        gap_d       = gap_q;
        ch_en_d     = ch_en_q;
        self_test_d = self_test_q;
        seq_d       = seq_q;
        done_d      = 1'b0;
        first_pick  = first_from(cfg_ch_en, 0);
        next_pick   = first_from(ch_en_q, int'(ch_q) + 1);
        if (pop && out_beat.sop) seq_d = seq_q + 8'd1;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_start || (cfg_again && state_q == S_DONE)) begin
                    len_sel_d   = cfg_data_len;
                    idle_sel_d  = cfg_idle_len;
                    gap_d       = cfg_gap;
                    ch_en_d     = cfg_ch_en;
                    self_test_d = cfg_self_test;
                    off_d       = '0;
                    issued_d    = 1'b0;
                    if (cfg_start) seq_d = 8'd0;
                    if (first_pick[CH_W]) begin
                        ch_d    = first_pick[CH_W-1:0];
                        state_d = S_READ;
                    end else begin
                        state_d = S_TAIL;
                        cnt_d   = tail_cnt(cfg_idle_len);
                    end
                end
            end
            S_READ: begin
                if (issue) begin
                    off_d = off_q + OFF_W'(1);
                    if (last_slot) issued_d = 1'b1;
                end
                if (pop && out_beat.eop) begin
                    off_d    = '0;
                    issued_d = 1'b0;
                    if (next_pick[CH_W]) begin
                        ch_d = next_pick[CH_W-1:0];
                        if (gap_q != 4'd0) begin
                            state_d = S_GAP;
                            cnt_d   = {4'd0, gap_q} - 8'd1;
                        end
                    end else begin
                        state_d = S_TAIL;
                        cnt_d   = tail_cnt(idle_sel_q);
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == 8'd0) state_d = S_READ;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_TAIL: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the buffer entries are reset too; they are only two registers and a clean reset
    // guarantees no stale beat can surface after rstn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            off_q       <= '0;
            issued_q    <= 1'b0;
            cnt_q       <= '0;
            len_sel_q   <= '0;
            idle_sel_q  <= '0;
            gap_q       <= '0;
            ch_en_q     <= '0;
            self_test_q <= 1'b0;
            seq_q       <= '0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_ch_q   <= '0;
            pend_off_q  <= '0;
            pend_sop_q  <= 1'b0;
            pend_eop_q  <= 1'b0;
            occ_q       <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            off_q       <= off_d;
            issued_q    <= issued_d;
            cnt_q       <= cnt_d;
            len_sel_q   <= len_sel_d;
            idle_sel_q  <= idle_sel_d;
            gap_q       <= gap_d;
            ch_en_q     <= ch_en_d;
            self_test_q <= self_test_d;
            seq_q       <= seq_d;
            done_q      <= done_d;
            pend_q      <= issue;
            pend_ch_q   <= ch_q;
            pend_off_q  <= off_q;
            pend_sop_q  <= (off_q == '0);
            pend_eop_q  <= last_slot;
            occ_q       <= occ_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
        end
    end
endmodule

// File: tb/tb_pkt_read_sequencer.sv
// Randomized self-checking bench for pkt_read_sequencer: a queue of expected beats is built
// from the packet rules and compared beat by beat, plus latency, gap, busy and reset checks.
module tb_pkt_read_sequencer;
    localparam int DATA_W   = 18;
    localparam int ADDR_W   = 16;
    localparam int NUM_CH   = 4;
    localparam int BASE_LEN = 216;
    localparam int CH_W     = 2;
    localparam int OFF_W    = ADDR_W - CH_W;
    localparam int BW       = DATA_W + CH_W + 2;
`ifdef PKT_SEQ_CHKSUM_EN
    localparam int CKS = 1;
`else
    localparam int CKS = 0;
`endif

    logic              clk, rstn;
    logic              cfg_start, cfg_again, cfg_self_test;
    logic [1:0]        cfg_data_len, cfg_idle_len;
    logic [3:0]        cfg_gap;
    logic [NUM_CH-1:0] cfg_ch_en;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata, dout;
    logic [CH_W-1:0]   dout_ch;
    logic              dout_sop, dout_eop, dout_valid, dout_ready, busy, done;
    logic [7:0]        seq_num;

    pkt_read_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .BASE_LEN(BASE_LEN)
    ) dut (
        .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_again(cfg_again),
        .cfg_data_len(cfg_data_len), .cfg_idle_len(cfg_idle_len), .cfg_gap(cfg_gap),
        .cfg_ch_en(cfg_ch_en), .cfg_self_test(cfg_self_test), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .dout(dout), .dout_ch(dout_ch),
        .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .busy(busy), .done(done), .seq_num(seq_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : DATA_W'($urandom);

    int pass_cnt = 0, chk_cnt = 0;
    logic [BW-1:0] exp_q[$];
    logic [7:0] exp_seq;
    int gap_g, low_cnt, rd_cnt, busy_cnt, done_cnt, beat_cnt;
    bit gap_chk, seen_eop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic monitor();
        logic [BW-1:0] got;
        if (!rstn) return;
        if (mem_rd_en)   rd_cnt++;
        if (busy)        busy_cnt++;
        if (done)        done_cnt++;
        if (!dout_valid) low_cnt++;
        if (dout_valid && dout_ready) begin
            got = {dout, dout_ch, dout_sop, dout_eop};
            if (exp_q.size() == 0) check("extra_beat", {1'b1, got}, 64'd0);
            else                   check("beat", got, exp_q.pop_front());
            if (dout_sop) begin
                check("seq_num_at_sop", seq_num, exp_seq);
                exp_seq++;
                if (seen_eop && gap_chk) check("gap_len", low_cnt, gap_g + 1);
            end
            if (dout_eop) begin
                seen_eop = 1'b1;
                low_cnt  = 0;
            end
            beat_cnt++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic build_exp(input logic [1:0] dl, input logic [NUM_CH-1:0] en, input bit st,
                             output int n, output int lbeats);
        int lb;
        logic [DATA_W-1:0] d, sum;
        lb = BASE_LEN << dl;
        n  = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!en[ch]) continue;
            n++;
            sum = '0;
            for (int off = 0; off < lb; off++) begin
                d = st ? DATA_W'({CH_W'(ch), OFF_W'(off)}) : mem[{CH_W'(ch), OFF_W'(off)}];
                sum += d;
                exp_q.push_back({d, CH_W'(ch), off == 0, (off == lb - 1) && (CKS == 0)});
            end
            if (CKS != 0) exp_q.push_back({sum, CH_W'(ch), 1'b0, 1'b1});
        end
        lbeats = lb + CKS;
    endtask

    task automatic run_pkt(input bit is_start, input logic [1:0] dl, input logic [1:0] il,
                           input logic [3:0] g, input logic [NUM_CH-1:0] en, input bit st,
                           input bit rnd_rdy, input string name);
        int n, lbeats, exp_busy, rd0, busy0, done0;
        bit got_done;
        build_exp(dl, en, st, n, lbeats);
        if (is_start) exp_seq = 8'd0;
        exp_busy = (n == 0) ? (16 << il) : n * (lbeats + 1) + (n - 1) * int'(g) + (16 << il);
        gap_g = int'(g); gap_chk = !rnd_rdy; seen_eop = 1'b0;
        rd0 = rd_cnt; busy0 = busy_cnt; done0 = done_cnt;
        cfg_data_len = dl; cfg_idle_len = il; cfg_gap = g; cfg_ch_en = en; cfg_self_test = st;
        cfg_start = is_start; cfg_again = !is_start;
        cycle();
        cfg_start = 1'b0; cfg_again = 1'b0;
        // Scramble the configuration after acceptance; the run must keep its shadow copy.
        cfg_data_len = 2'($urandom); cfg_idle_len = 2'($urandom); cfg_gap = 4'($urandom);
        cfg_ch_en = 4'($urandom); cfg_self_test = 1'($urandom);
        got_done = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            dout_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (c == 5) cfg_again = 1'b1;
            if (c == 7) begin cfg_again = 1'b0; cfg_start = 1'b1; end
            if (c == 8) cfg_start = 1'b0;
            @(negedge clk);
            monitor();
            if (c == 0) begin
                check({name, "_first_rd_en"}, mem_rd_en, (n != 0) && !st);
                check({name, "_busy_on"}, busy, 1);
            end
            if (c == 1 && n != 0) check({name, "_first_valid"}, dout_valid, 1);
            if (done) begin got_done = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        if (!got_done) check({name, "_done_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        dout_ready = 1'b1;
        repeat (4) cycle();
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        check({name, "_done_pulses"}, done_cnt - done0, 1);
        check({name, "_mem_reads"}, rd_cnt - rd0, st ? 0 : n * (lbeats - CKS));
        if (!rnd_rdy) check({name, "_busy_cycles"}, busy_cnt - busy0, exp_busy);
        check({name, "_seq_end"}, seq_num, exp_seq);
        check({name, "_busy_off"}, busy, 0);
    endtask

    task automatic reset_mid();
        int n, lbeats, b0, rd0;
        build_exp(2'b00, 4'b0001, 1'b0, n, lbeats);
        exp_seq = 8'd0; seen_eop = 1'b0; gap_chk = 1'b0;
        cfg_data_len = 2'b00; cfg_idle_len = 2'b00; cfg_gap = 4'd2; cfg_ch_en = 4'b0001;
        cfg_self_test = 1'b0; cfg_start = 1'b1; dout_ready = 1'b1;
        cycle();
        cfg_start = 1'b0;
        b0 = beat_cnt;
        for (int c = 0; c < 1000; c++) begin
            if (beat_cnt - b0 >= 100) break;
            cycle();
        end
        check("rst_beats_before", beat_cnt - b0, 100);
        rstn = 1'b0;
        #1;
        check("rst_mid_outputs", {mem_rd_en, mem_addr, dout, dout_ch, dout_sop, dout_eop,
                                  dout_valid, busy, done, seq_num}, 64'd0);
        exp_q.delete();
        repeat (3) cycle();
        rstn = 1'b1;
        rd0 = rd_cnt; b0 = beat_cnt;
        cycle();
        cfg_again = 1'b1;
        cycle();
        cfg_again = 1'b0;
        repeat (40) cycle();
        check("rst_no_beats_after", beat_cnt - b0, 0);
        check("rst_no_reads_after", rd_cnt - rd0, 0);
        check("rst_idle_busy", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'($urandom);
        rstn = 1'b0; cfg_start = 1'b0; cfg_again = 1'b0; cfg_data_len = '0; cfg_idle_len = '0;
        cfg_gap = '0; cfg_ch_en = '0; cfg_self_test = 1'b0; dout_ready = 1'b1;
        exp_seq = 8'd0; low_cnt = 0; rd_cnt = 0; busy_cnt = 0; done_cnt = 0; beat_cnt = 0;
        gap_g = 0; gap_chk = 1'b0; seen_eop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {mem_rd_en, mem_addr, dout, dout_ch, dout_sop, dout_eop,
                                dout_valid, busy, done, seq_num}, 64'd0);
        rstn = 1'b1;
        repeat (2) cycle();

        run_pkt(1'b1, 2'b01, 2'b01, 4'd4, 4'b0101, 1'b0, 1'b0, "basic");
        run_pkt(1'b0, 2'b01, 2'b01, 4'd4, 4'b0101, 1'b0, 1'b0, "replay");
        run_pkt(1'b1, 2'b00, 2'b00, 4'd0, 4'b1111, 1'b0, 1'b0, "gap0_all_ch");
        run_pkt(1'b1, 2'b00, 2'b00, 4'd2, 4'b1000, 1'b1, 1'b0, "self_test");
        run_pkt(1'b1, 2'b11, 2'b00, 4'd3, 4'b0001, 1'b0, 1'b1, "rand_ready");
        run_pkt(1'b1, 2'b00, 2'b00, 4'd5, 4'b0000, 1'b0, 1'b0, "no_channels");
        for (int r = 0; r < 4; r++)
            run_pkt(1'($urandom), 2'($urandom_range(0, 1)), 2'($urandom), 4'($urandom),
                    4'($urandom), 1'($urandom), 1'($urandom), "random");
        reset_mid();
        run_pkt(1'b1, 2'b00, 2'b00, 4'd1, 4'b0110, 1'b0, 1'b0, "post_reset");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
